// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC, redirects it on taken branches/jumps,
// squashes wrong-path fetches and halts fetch on misaligned targets.
// Optional build macro PC_REDIRECT_STATS_EN adds branch/taken statistics counters.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_RUN     | normal fetch; EX control transfers are evaluated
// ST_FLUSH   | post-redirect window; Flush_o high, EX transfers ignored
// ST_HALT    | misaligned target seen; PC frozen until reset
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        Clk_i,
  input  logic        Rst_i,
  input  logic        Stall_i,
  input  logic        BranchValid_i,
  input  logic        Branch_i,
  input  logic        Jal_i,
  input  logic        Jalr_i,
  input  logic        Flag_i,
  input  logic [31:0] CurPC_i,
  input  logic [31:0] Imm_i,
  input  logic [31:0] Rs1_i,
  output logic [31:0] PC_o,
  output logic [31:0] LinkAddr_o,
  output logic        Redirect_o,
  output logic        Flush_o,
  output logic        MisalignErr_o
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0] BranchCnt_o,
  output logic [31:0] TakenCnt_o
`endif
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // The first flush cycle is the redirect cycle itself, so the counter
  // covers the remaining FLUSH_CYCLES-1 cycles down to terminal count 0.
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        redirect_q, redirect_d;
  logic        flush_q, flush_d;
  logic        err_q, err_d;

  logic        take;
  logic        aligned;
  logic [31:0] sum_jalr;
  logic [31:0] sum_pc;
  logic [31:0] target;
  logic [31:0] pc_seq;

  // Target selection: JALR wins over JAL, JAL over conditional branch.
  always_comb begin
    take     = BranchValid_i & (Jalr_i | Jal_i | (Branch_i & Flag_i));
    sum_jalr = Rs1_i + Imm_i;
    sum_pc   = CurPC_i + Imm_i;
    target   = Jalr_i ? (sum_jalr & ~32'd1) : sum_pc;
    aligned  = (target[1:0] == 2'b00);
    pc_seq   = pc_q + 32'd4;
  end

  // Next-state and next-PC decision.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    flush_d    = flush_q;
    err_d      = err_q;
    case (state_q)
      ST_RUN: begin
        flush_d = 1'b0;
        if (take && aligned) begin
          pc_d       = target;
          redirect_d = 1'b1;
          flush_d    = 1'b1;
          cnt_d      = FLUSH_INIT;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
          end
        end else if (take) begin
          err_d   = 1'b1;
          flush_d = 1'b1;
          state_d = ST_HALT;
        end else if (!Stall_i) begin
          pc_d = pc_seq;
        end
      end
      ST_FLUSH: begin
        flush_d = 1'b1;
        if (!Stall_i) begin
          pc_d = pc_seq;
        end
        if (cnt_q == 3'd0) begin
          state_d = ST_RUN;
          flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_HALT: begin
        flush_d = 1'b1;
        err_d   = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        flush_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state_q    <= ST_RUN;
      cnt_q      <= 3'd0;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
      err_q      <= err_d;
    end
  end

  assign PC_o          = pc_q;
  assign LinkAddr_o    = CurPC_i + 32'd4;
  assign Redirect_o    = redirect_q;
  assign Flush_o       = flush_q;
  assign MisalignErr_o = err_q;

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] taken_cnt_q;

  // Statistics: only transfers evaluated in RUN are counted; both wrap.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      branch_cnt_q <= 32'd0;
      taken_cnt_q  <= 32'd0;
    end else if (state_q == ST_RUN) begin
      if (BranchValid_i && Branch_i) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if (take && aligned) begin
        taken_cnt_q <= taken_cnt_q + 32'd1;
      end
    end
  end

  assign BranchCnt_o = branch_cnt_q;
  assign TakenCnt_o  = taken_cnt_q;
`else
  // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: two instances (FLUSH_CYCLES 1 and 3)
// share the stimulus; each phase resets both and checks the relevant one.
module tb_pc_redirect_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        stall, bvalid, branch, jal, jalr, flag;
  logic [31:0] cur_pc, imm, rs1;

  logic [31:0] pc1, link1, pc3, link3;
  logic        redir1, flush1, err1, redir3, flush3, err3;
`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] bcnt1, tcnt1, bcnt3, tcnt3;
`endif

  typedef struct {
    logic [31:0] pc;
    logic        redir;
    logic        flush;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  pc_redirect_unit #(.RESET_PC(RST_PC), .FLUSH_CYCLES(1)) u_dut1 (
    .Clk_i(clk), .Rst_i(rst), .Stall_i(stall), .BranchValid_i(bvalid),
    .Branch_i(branch), .Jal_i(jal), .Jalr_i(jalr), .Flag_i(flag),
    .CurPC_i(cur_pc), .Imm_i(imm), .Rs1_i(rs1),
    .PC_o(pc1), .LinkAddr_o(link1), .Redirect_o(redir1), .Flush_o(flush1),
    .MisalignErr_o(err1)
`ifdef PC_REDIRECT_STATS_EN
    , .BranchCnt_o(bcnt1), .TakenCnt_o(tcnt1)
`endif
  );

  pc_redirect_unit #(.RESET_PC(RST_PC), .FLUSH_CYCLES(3)) u_dut3 (
    .Clk_i(clk), .Rst_i(rst), .Stall_i(stall), .BranchValid_i(bvalid),
    .Branch_i(branch), .Jal_i(jal), .Jalr_i(jalr), .Flag_i(flag),
    .CurPC_i(cur_pc), .Imm_i(imm), .Rs1_i(rs1),
    .PC_o(pc3), .LinkAddr_o(link3), .Redirect_o(redir3), .Flush_o(flush3),
    .MisalignErr_o(err3)
`ifdef PC_REDIRECT_STATS_EN
    , .BranchCnt_o(bcnt3), .TakenCnt_o(tcnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic br, input logic j, input logic jr,
                       input logic f, input logic st,
                       input logic [31:0] cur, input logic [31:0] im, input logic [31:0] r1);
    bvalid = v;  branch = br; jal = j; jalr = jr; flag = f; stall = st;
    cur_pc = cur; imm = im; rs1 = r1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic rd, input logic fl, input logic er);
    exp_t e;
    e.pc = pc; e.redir = rd; e.flush = fl; e.err = er;
    sb_q.push_back(e);
  endtask

  task automatic compare_out(input string tag, input bit sel3);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got empty scoreboard, expected an entry", tag);
      return;
    end
    e = sb_q.pop_front();
    if (sel3) begin
      check({tag, ".pc"},    pc3,           e.pc);
      check({tag, ".redir"}, {31'd0, redir3}, {31'd0, e.redir});
      check({tag, ".flush"}, {31'd0, flush3}, {31'd0, e.flush});
      check({tag, ".err"},   {31'd0, err3},   {31'd0, e.err});
    end else begin
      check({tag, ".pc"},    pc1,           e.pc);
      check({tag, ".redir"}, {31'd0, redir1}, {31'd0, e.redir});
      check({tag, ".flush"}, {31'd0, flush1}, {31'd0, e.flush});
      check({tag, ".err"},   {31'd0, err1},   {31'd0, e.err});
    end
  endtask

  // Expectation is queued with the stimulus already applied, then checked
  // one clock later once the DUT has registered its decision.
  task automatic step(input string tag, input bit sel3, input logic [31:0] pc,
                      input logic rd, input logic fl, input logic er);
    push_exp(pc, rd, fl, er);
    @(posedge clk);
    #1;
    compare_out(tag, sel3);
  endtask

  // Asynchronous reset between clock edges; outputs must return at once.
  task automatic reset_check(input string tag, input bit sel3);
    push_exp(RST_PC, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    compare_out(tag, sel3);
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    push_exp(RST_PC, 1'b0, 1'b0, 1'b0);
    compare_out("reset1", 1'b0);
    push_exp(RST_PC, 1'b0, 1'b0, 1'b0);
    compare_out("reset3", 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch
    step("seq0", 1'b0, 32'h104, 1'b0, 1'b0, 1'b0);
    step("seq1", 1'b0, 32'h108, 1'b0, 1'b0, 1'b0);
    step("seq2", 1'b0, 32'h10C, 1'b0, 1'b0, 1'b0);

    // BEQ taken, then not taken
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h40, 32'h0);
    #1 check("beq_link", link1, 32'h204);
    step("beq_taken", 1'b0, 32'h240, 1'b1, 1'b1, 1'b0);
    idle();
    step("beq_after", 1'b0, 32'h244, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h40, 32'h0);
    step("beq_nt", 1'b0, 32'h248, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    step("stall_hold", 1'b0, 32'h248, 1'b0, 1'b0, 1'b0);

    // JAL overrides stall; backwards offset
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'hFFFF_FFF8, 32'h0);
    #1 check("jal_link", link1, 32'h304);
    step("jal_stall", 1'b0, 32'h2F8, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    step("jal_hold", 1'b0, 32'h2F8, 1'b0, 1'b0, 1'b0);

    // JAL and JALR together: JALR target with bit0 cleared
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h10, 32'h1001);
    step("jalr_prio", 1'b0, 32'h1010, 1'b1, 1'b1, 1'b0);

    // Target wraps modulo 2^32
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h8, 32'h0);
    step("wrap", 1'b0, 32'h4, 1'b1, 1'b1, 1'b0);

    // Not valid: branch with flag is not taken
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h800, 32'h40, 32'h0);
    step("novalid", 1'b0, 32'h8, 1'b0, 1'b0, 1'b0);

    // JALR misaligned: halt
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h900, 32'h0, 32'h1003);
    step("misalign", 1'b0, 32'h8, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom & 32'hFFFF_FFFC, 32'h40, 32'h0);
      step("halt", 1'b0, 32'h8, 1'b0, 1'b1, 1'b1);
    end
    reset_check("halt_reset", 1'b0);
    step("post_halt", 1'b0, 32'h104, 1'b0, 1'b0, 1'b0);

    // Three-cycle flush window on the second instance
    reset_check("f3_reset", 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h500, 32'h20, 32'h0);
    step("f3_redir", 1'b1, 32'h520, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h600, 32'h100, 32'h0);
    step("f3_ign1", 1'b1, 32'h524, 1'b0, 1'b1, 1'b0);
    step("f3_ign2", 1'b1, 32'h528, 1'b0, 1'b1, 1'b0);
    step("f3_ign3", 1'b1, 32'h52C, 1'b0, 1'b0, 1'b0);
    step("f3_jal", 1'b1, 32'h700, 1'b1, 1'b1, 1'b0);
    reset_check("f3_midflush_reset", 1'b1);
    step("f3_post", 1'b1, 32'h104, 1'b0, 1'b0, 1'b0);

`ifdef PC_REDIRECT_STATS_EN
    reset_check("st_reset", 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, (i == 0 || i == 3), 1'b0, 32'h1000, 32'h40, 32'h0);
      @(posedge clk);
      #1;
    end
    idle();
    check("st_bcnt", bcnt1, 32'd5);
    check("st_tcnt", tcnt1, 32'd2);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1000, 32'h40, 32'h0);
    @(posedge clk);
    #1;
    check("st_inflush", {31'd0, flush3}, 32'd1);
    reset_check("st_midflush_reset", 1'b1);
    check("st_bcnt3_rst", bcnt3, 32'd0);
    check("st_tcnt3_rst", tcnt3, 32'd0);
    check("st_bcnt1_rst", bcnt1, 32'd0);
    check("st_tcnt1_rst", tcnt1, 32'd0);
`endif

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_drain: got %0d leftover entries, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
